// File: rtl/mult_cu_seq.sv
// Sequential shift-add multiplier with control unit.
// Retires one multiplier bit per clock; signed mode works on magnitudes.
module mult_cu_seq #(
    parameter int          WIDTH    = 16,
    parameter logic [3:0]  OP_MULTU = 4'b1000,
    parameter logic [3:0]  OP_MULT  = 4'b1010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           control,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 validity,
    output logic                 busy,
    output logic [5:0]           iteration
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     mreg;
    logic [WIDTH-1:0]     mcand;
    logic                 neg;

    logic                 is_signed;
    logic                 is_start;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   full;
    logic [2*WIDTH-1:0]   full_neg;

    always_comb begin
        is_signed = (control == OP_MULT);
        is_start  = (control == OP_MULTU) || is_signed;
        // -(2^(W-1)) wraps to itself, which is the correct unsigned magnitude
        abs_a = (is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
        abs_b = (is_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
        sum = {1'b0, acc} + {1'b0, (mreg[0] ? mcand : {WIDTH{1'b0}})};
        full = {acc, mreg};
        full_neg = -full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            product   <= '0;
            validity  <= 1'b0;
            busy      <= 1'b0;
            iteration <= '0;
            acc       <= '0;
            mreg      <= '0;
            mcand     <= '0;
            neg       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_start) begin
                        mcand     <= abs_a;
                        mreg      <= abs_b;
                        acc       <= '0;
                        neg       <= is_signed &&
                                     (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                        iteration <= '0;
                        busy      <= 1'b1;
                        validity  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc       <= sum[WIDTH:1];
                    mreg      <= {sum[0], mreg[WIDTH-1:1]};
                    iteration <= iteration + 6'd1;
                    if (iteration == 6'(WIDTH-1))
                        state <= FIX;
                end
                FIX: begin
                    product  <= neg ? full_neg : full;
                    validity <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_cu_seq.sv
// Directed bench for mult_cu_seq: vector table plus
// hand-written reset, busy-start and idle-code sequences.
module tb_mult_cu_seq;

    localparam int W = 16;
    localparam logic [3:0] MU = 4'b1000;
    localparam logic [3:0] MS = 4'b1010;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      control;
    logic [W-1:0]    multiplicand;
    logic [W-1:0]    multiplier;
    logic [2*W-1:0]  product;
    logic            validity;
    logic            busy;
    logic [5:0]      iteration;

    int n_chk = 0;
    int n_fail = 0;

    mult_cu_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .control(control),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .product(product),
        .validity(validity),
        .busy(busy),
        .iteration(iteration)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]     ctrl;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a start code so that the next edge is E0; returns at E0+1.
    task automatic start(input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        control = c;
        multiplicand = a;
        multiplier = b;
        tick();
        control = 4'b0000;
        multiplicand = 16'h5A5A;
        multiplier = 16'hA5A5;
    endtask

    // Full operation from E0 to E17 with checks at key edges.
    task automatic do_mul(input string nm, input vec_t v);
        start(v.ctrl, v.a, v.b);
        chk({nm, " E0 validity"}, validity, 0);
        chk({nm, " E0 busy"}, busy, 1);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) begin
                chk({nm, " E16 busy"}, busy, 1);
                chk({nm, " E16 validity"}, validity, 0);
            end
        end
        chk({nm, " product"}, product, v.exp);
        chk({nm, " validity"}, validity, 1);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " iteration"}, iteration, 16);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{MU, 16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{MU, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{MS, 16'hFFFD, 16'h0005, 32'hFFFFFFF1};
        vecs[3] = '{MS, 16'h8000, 16'h8000, 32'h40000000};
        vecs[4] = '{MS, 16'h8000, 16'h0001, 32'hFFFF8000};
        vecs[5] = '{MS, 16'h0000, 16'hFFF9, 32'h00000000};
        vecs[6] = '{MU, 16'hFFFD, 16'h0005, 32'h0004FFF1};
        vecs[7] = '{MS, 16'h8000, 16'hFFFF, 32'h00008000};
        vecs[8] = '{MS, 16'hFFFE, 16'hFFFA, 32'h0000000C};

        rst = 1'b1;
        control = 4'b0000;
        multiplicand = '0;
        multiplier = '0;
        #1;
        chk("reset product", product, 0);
        chk("reset validity", validity, 0);
        chk("reset busy", busy, 0);
        chk("reset iteration", iteration, 0);
        #10;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++)
            do_mul($sformatf("vec%0d", i), vecs[i]);

        // validity sticks through idle cycles
        for (int k = 0; k < 10; k++) tick();
        chk("sticky validity", validity, 1);
        chk("sticky product", product, 32'h0000000C);

        // non-start codes leave everything unchanged
        control = 4'b1001;
        multiplicand = 16'h1234;
        multiplier = 16'h4321;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) control = 4'b0000;
            tick();
        end
        chk("idle busy", busy, 0);
        chk("idle validity", validity, 1);
        chk("idle product", product, 32'h0000000C);
        chk("idle iteration", iteration, 16);

        // start while busy ignored, then back-to-back start
        start(MU, 16'd2, 16'd2);
        for (int k = 1; k <= 17; k++) begin
            if (k == 5) begin
                control = MS;
                multiplicand = 16'd9;
                multiplier = 16'd9;
            end
            tick();
            if (k == 5) begin
                control = 4'b0000;
                chk("busy start iter", iteration, 5);
            end
        end
        chk("busy start product", product, 32'd4);
        chk("busy start validity", validity, 1);
        start(MU, 16'd3, 16'd4);
        chk("b2b E18 validity", validity, 0);
        chk("b2b E18 product hold", product, 32'd4);
        for (int k = 1; k <= 17; k++) tick();
        chk("b2b E35 product", product, 32'd12);
        chk("b2b E35 validity", validity, 1);

        // asynchronous reset mid-run
        start(MU, 16'd3, 16'd5);
        for (int k = 1; k <= 8; k++) tick();
        chk("pre-reset busy", busy, 1);
        chk("pre-reset iteration", iteration, 8);
        #2 rst = 1'b1;
        #1;
        chk("async product", product, 0);
        chk("async validity", validity, 0);
        chk("async busy", busy, 0);
        chk("async iteration", iteration, 0);
        #1 rst = 1'b0;
        tick();
        chk("post-reset busy", busy, 0);
        do_mul("after reset", '{MU, 16'd7, 16'd6, 32'd42});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_cu_seq.md
Name: mult_cu_seq

Overview:
- Sequential shift-add multiplier with built-in control unit. It is the multiply-side counterpart of the divider control unit, and is decoded from the same 4-bit `control` bus.
- It takes two WIDTH-bit operands and produces a 2*WIDTH-bit product, retiring one multiplier bit per clock.
- It sits beside the divider in the MIPS ALU datapath. HI/LO writeback waits on `validity`.

Parameters:
- WIDTH, 16, operand width in bits. The product is 2*WIDTH bits.
- OP_MULTU, 4'b1000, control code for an unsigned multiply start.
- OP_MULT, 4'b1010, control code for a signed (two's complement) multiply start.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- control  input  4  operation code, sampled on posedge in IDLE.
- multiplicand  input  WIDTH  operand A, captured on the start edge.
- multiplier  input  WIDTH  operand B, captured on the start edge.
- product  output  2*WIDTH  result register.
- validity  output  1  product valid; sticky.
- busy  output  1  high while iterating.
- iteration  output  6  current iteration count, for debug/visibility.

Behaviour:
- Reset (async, immediate, any state including mid-operation):
  - state=IDLE; product=0; validity=0; busy=0; iteration=0.
  - Internal acc, mreg, mcand and neg flag cleared.
  - No partial result survives reset.
- States: IDLE, RUN, FIX.
- IDLE, on posedge with control==OP_MULTU or OP_MULT (the start edge E0):
  - For OP_MULT, operands are converted to their magnitudes; neg = signA XOR signB. For OP_MULTU, neg=0.
  - mcand <= |A|; mreg <= |B|; acc <= 0; iteration <= 0; busy <= 1; validity <= 0; state <= RUN.
  - Other control codes: stay in IDLE, all outputs hold.
- RUN, each posedge:
  - sum (WIDTH+1 bits) = acc + (mreg[0] ? mcand : 0).
  - {acc, mreg} <= {sum, acc_low_bits, mreg} shifted right by 1; concretely acc <= sum[WIDTH:1], mreg <= {sum[0], mreg[WIDTH-1:1]}.
  - iteration <= iteration + 1.
  - When iteration == WIDTH-1 on this edge, next state is FIX.
- FIX, one posedge:
  - product <= neg ? two's-complement negation of {acc, mreg} : {acc, mreg}.
  - validity <= 1; busy <= 0; state <= IDLE; iteration stays at WIDTH.
- Latency: E0 is the start edge, E1..E16 are RUN edges (WIDTH=16), and E17 is the FIX edge. product and validity update at E17, i.e. 17 clocks after the start edge.
- validity is sticky high until the next accepted start edge, where it clears, or until reset. product holds its value until the next FIX.
- Start codes arriving while busy (RUN or FIX) are ignored; no queuing. Operand changes after E0 have no effect.
- A start code in IDLE on the same edge validity would otherwise stay high is accepted: validity drops at that edge.
- Signed boundaries:
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), representable in WIDTH unsigned bits. No overflow; the result is exact in 2*WIDTH bits.
  - A zero operand with neg=1 yields product 0, since the negation of 0 is 0.
- Arithmetic width rule: the sum is WIDTH+1 bits so the carry is never lost. Product is exact for all operand pairs in both modes.
- control, multiplicand and multiplier are treated as synchronous to clk. No output is combinational from any input.

Test Plan:
- Reset mid-run: start OP_MULTU 3×5, assert rst at E8 → all outputs 0 immediately (async). After release, a new start 7×6 → product=42 at E17.
- Unsigned basic: OP_MULTU, A=16'h0003, B=16'h0005 → busy=1 during E1..E16; product=32'h0000000F and validity=1 at E17. validity stays 1 for 10 idle cycles.
- Unsigned max: OP_MULTU, A=B=16'hFFFF → product=32'hFFFE0001 at E17.
- Signed: OP_MULT with A=-3 (16'hFFFD), B=5 → product=32'hFFFFFFF1. A=16'h8000, B=16'h8000 → 32'h40000000. A=16'h8000, B=1 → 32'hFFFF8000. A=0, B=-7 → 0.
- Start while busy: OP_MULTU 2×2, re-drive OP_MULT 9×9 at E5 → ignored; product=4 at E17. A back-to-back start at E18 clears validity at E18 and produces a new result at E35.
- Non-start codes (4'b1001, 4'b0000) held in IDLE for 20 cycles → busy, validity, product and iteration unchanged.
